// File: rtl/y86_regfile_if.sv
// rtl/y86_regfile_if.sv - decode/regfile port bundle: read IDs and data, write IDs and data, debug read
interface y86_regfile_if #(
    parameter int W = 64
);
    logic         we;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [W-1:0] valE;
    logic [3:0]   dstM;
    logic [W-1:0] valM;
    logic [3:0]   dbg_sel;
    logic [W-1:0] dbg_val;

    modport master (
        output we, srcA, srcB, dstE, valE, dstM, valM, dbg_sel,
        input  valA, valB, dbg_val
    );

    modport slave (
        input  we, srcA, srcB, dstE, valE, dstM, valM, dbg_sel,
        output valA, valB, dbg_val
    );
endinterface

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - Y86-64 register file, 15 x W, two comb reads + debug read, two sync writes
// Optional write-through reads when REGFILE_BYPASS_EN is defined.
module y86_regfile #(
    parameter int           W        = 64,
    parameter logic [W-1:0] RSP_INIT = '0
) (
    input  logic           clk,
    input  logic           rst,
    y86_regfile_if.slave   rf
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [W-1:0] regs [0:14];

    // M is assigned after E so a same-ID collision leaves valM in the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
            regs[RRSP] <= RSP_INIT;
        end else if (rf.we) begin
            if (rf.dstE != RNONE) begin
                regs[rf.dstE] <= rf.valE;
            end
            if (rf.dstM != RNONE) begin
                regs[rf.dstM] <= rf.valM;
            end
        end
    end

    logic [3:0]   rd_sel [0:2];
    logic [W-1:0] rd_val [0:2];

    assign rd_sel[0] = rf.srcA;
    assign rd_sel[1] = rf.srcB;
    assign rd_sel[2] = rf.dbg_sel;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_val[p] = '0;
            if (rd_sel[p] != RNONE) begin
                rd_val[p] = regs[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
                if (!rst && rf.we) begin
                    if (rf.dstE == rd_sel[p]) begin
                        rd_val[p] = rf.valE;
                    end
                    if (rf.dstM == rd_sel[p]) begin
                        rd_val[p] = rf.valM;
                    end
                end
`endif
            end
        end
    end

    assign rf.valA    = rd_val[0];
    assign rf.valB    = rd_val[1];
    assign rf.dbg_val = rd_val[2];
endmodule

// File: tb/tb_y86_regfile.sv
// tb/tb_y86_regfile.sv - table-driven and scoreboarded bench for y86_regfile
module tb_y86_regfile;
    localparam logic [63:0] RSP_INIT = 64'h200;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    y86_regfile_if #(.W(64)) rf ();

    y86_regfile #(.W(64), .RSP_INIT(RSP_INIT)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    typedef struct {
        logic        we;
        logic [3:0]  dstE;
        logic [63:0] valE;
        logic [3:0]  dstM;
        logic [63:0] valM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [63:0] expA;
        logic [63:0] expB;
    } vec_t;

    vec_t        vecs [0:6];
    logic [63:0] m [0:14];
    string       name_q [$];
    logic [63:0] exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic expect_val(input string n, input logic [63:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] act);
        string       n;
        logic [63:0] e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h, no expected value queued", act);
        end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            if (act === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    endtask

    task automatic tick();
        logic [63:0] nm [0:14];
        nm = m;
        if (rst) begin
            for (int i = 0; i < 15; i++) nm[i] = '0;
            nm[4] = RSP_INIT;
        end else if (rf.we) begin
            if (rf.dstE != 4'hF) nm[rf.dstE] = rf.valE;
            if (rf.dstM != 4'hF) nm[rf.dstM] = rf.valM;
        end
        @(posedge clk);
        m = nm;
        #1;
    endtask

    task automatic full_compare(input string tag);
        rf.we = 1'b0;
        for (int id = 0; id < 15; id++) begin
            rf.dbg_sel = id[3:0];
            #1;
            expect_val($sformatf("%s_reg%0d", tag, id), m[id]);
            check(rf.dbg_val);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd2,  64'h11,   4'd3,  64'h22,   4'd2,  4'd3,  64'h11,   64'h22};
        vecs[1] = '{1'b1, 4'd4,  64'hAAAA, 4'd4,  64'hBBBB, 4'd4,  4'd2,  64'hBBBB, 64'h11};
        vecs[2] = '{1'b0, 4'd5,  64'h55,   4'hF,  64'h0,    4'd5,  4'd4,  64'h0,    64'hBBBB};
        vecs[3] = '{1'b1, 4'hF,  64'hDEAD, 4'hF,  64'hBEEF, 4'hF,  4'd3,  64'h0,    64'h22};
        vecs[4] = '{1'b1, 4'd14, 64'hE0E0, 4'd0,  64'h0101, 4'd14, 4'd0,  64'hE0E0, 64'h0101};
        vecs[5] = '{1'b0, 4'd2,  64'h99,   4'd3,  64'h98,   4'd2,  4'd3,  64'h11,   64'h22};
        vecs[6] = '{1'b1, 4'd7,  64'h1,    4'hF,  64'h0,    4'd7,  4'd14, 64'h1,    64'hE0E0};

        for (int i = 0; i < 15; i++) m[i] = 'x;
        rst = 1'b1;
        rf.we = 1'b0; rf.srcA = 4'hF; rf.srcB = 4'hF; rf.dbg_sel = 4'hF;
        rf.dstE = 4'hF; rf.valE = '0; rf.dstM = 4'hF; rf.valM = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;

        for (int id = 0; id < 16; id++) begin
            @(negedge clk);
            rf.srcA = id[3:0]; rf.srcB = id[3:0]; rf.dbg_sel = id[3:0];
            #1;
            expect_val($sformatf("reset_valA_id%0d", id), (id == 4) ? RSP_INIT : 64'h0);
            check(rf.valA);
            expect_val($sformatf("reset_valB_id%0d", id), (id == 4) ? RSP_INIT : 64'h0);
            check(rf.valB);
            expect_val($sformatf("reset_dbg_id%0d", id), (id == 4) ? RSP_INIT : 64'h0);
            check(rf.dbg_val);
        end

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            rf.we = vecs[v].we;
            rf.dstE = vecs[v].dstE; rf.valE = vecs[v].valE;
            rf.dstM = vecs[v].dstM; rf.valM = vecs[v].valM;
            rf.srcA = vecs[v].srcA; rf.srcB = vecs[v].srcB;
            tick();
            rf.we = 1'b0;
            expect_val($sformatf("vec%0d_valA", v), vecs[v].expA);
            expect_val($sformatf("vec%0d_valB", v), vecs[v].expB);
            #1;
            check(rf.valA);
            check(rf.valB);
            full_compare($sformatf("vec%0d", v));
        end

        // read-during-write on regs[7] (holds 1)
        @(negedge clk);
        rf.we = 1'b1; rf.dstE = 4'd7; rf.valE = 64'h9; rf.dstM = 4'hF;
        rf.srcA = 4'd7;
`ifdef REGFILE_BYPASS_EN
        expect_val("rdw_before_edge", 64'h9);
`else
        expect_val("rdw_before_edge", 64'h1);
`endif
        #1;
        check(rf.valA);
        tick();
        rf.we = 1'b0;
        expect_val("rdw_after_edge", 64'h9);
        #1;
        check(rf.valA);

        // same-ID collision seen through the read port before the edge
        @(negedge clk);
        rf.we = 1'b1; rf.dstE = 4'd8; rf.valE = 64'h1; rf.dstM = 4'd8; rf.valM = 64'h2;
        rf.srcB = 4'd8;
`ifdef REGFILE_BYPASS_EN
        expect_val("collide_before_edge", 64'h2);
`else
        expect_val("collide_before_edge", 64'h0);
`endif
        #1;
        check(rf.valB);
        tick();
        rf.we = 1'b0;
        expect_val("collide_after_edge", 64'h2);
        #1;
        check(rf.valB);

        // reset mid-stream discards a concurrent write
        @(negedge clk);
        rf.we = 1'b1; rf.dstE = 4'd1; rf.valE = 64'h77; rf.dstM = 4'hF;
        tick();
        @(negedge clk);
        rst = 1'b1;
        rf.we = 1'b1; rf.dstE = 4'd1; rf.valE = 64'hF0; rf.srcA = 4'd1;
        expect_val("rst_before_edge", 64'h77);
        #1;
        check(rf.valA);
        tick();
        rst = 1'b0;
        rf.we = 1'b0;
        expect_val("rst_after_edge", 64'h0);
        #1;
        check(rf.valA);
        full_compare("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
